// File: rtl/crc_serial_engine_pkg.sv
// crc_serial_engine_pkg: state encoding, width limit and the bit-serial CRC step shared by the engine
package crc_serial_engine_pkg;
  localparam int CRC_W_MAX = 32;
  typedef enum logic [1:0] {IDLE, CALC, SHIFT, CHECK} crc_state_e;
  // Reflected LFSR step on a zero-extended W-bit state; the MSB always takes the raw feedback.
  function automatic logic [CRC_W_MAX-1:0] crc_step(
    input logic [CRC_W_MAX-1:0] s,
    input logic                 d,
    input logic [CRC_W_MAX-1:0] poly,
    input int                   w
  );
    logic                 fb;
    logic [CRC_W_MAX-1:0] top;
    fb  = d ^ s[0];
    top = {{(CRC_W_MAX-1){1'b0}}, 1'b1} << (w - 1);
    return (((s >> 1) ^ (poly & {CRC_W_MAX{fb}})) & ~top) | (fb ? top : '0);
  endfunction
endpackage

// File: rtl/crc_serial_engine_lfsr.sv
// crc_serial_engine_lfsr: W-bit CRC register that restarts from SEED or advances one data bit per clock
module crc_serial_engine_lfsr
  import crc_serial_engine_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic         data,
  output logic [W-1:0] lfsr_q
);
  logic [W-1:0] base;
  logic [W-1:0] lfsr_d;
  always_comb begin
    base   = start ? SEED : lfsr_q;
    lfsr_d = (start | step) ? W'(crc_step(CRC_W_MAX'(base), data, CRC_W_MAX'(POLY), W)) : lfsr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial CRC generator/checker with framing FSM, serial output and status flags
module crc_serial_engine
  import crc_serial_engine_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(8'h44),
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'(8'hD8),
  parameter logic [CRC_WIDTH-1:0] FINAL_XOR = CRC_WIDTH'(8'h00)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data,
  input  logic active,
  input  logic mode,
  output logic crc,
  output logic valid,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int            CW   = $clog2(CRC_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(CRC_WIDTH - 1);
  crc_state_e           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0] out_sr_q, out_sr_d;
  logic                 crc_q, crc_d, valid_q, valid_d, busy_q, busy_d;
  logic                 done_q, done_d, err_q, err_d;
  logic [CRC_WIDTH-1:0] lfsr_q;
  logic                 start, lfsr_step, out_phase, last, miss;
  crc_serial_engine_lfsr #(.W(CRC_WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .start(start), .step(lfsr_step), .data(data), .lfsr_q(lfsr_q)
  );
  // Any ACTIVE outside CALC begins a frame, including an abort of the output window.
  assign start     = active & (state_q != CALC);
  assign lfsr_step = active & (state_q == CALC);
  assign out_phase = (state_q == SHIFT) | (state_q == CHECK);
  assign last      = cnt_q == LAST;
  assign miss      = (state_q == CHECK) & (data ^ out_sr_q[cnt_q]);
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    out_sr_d = out_sr_q;
    crc_d    = crc_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (start) begin
      state_d = CALC;
      mode_d  = mode;
      crc_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      err_d   = 1'b0;
      done_d  = out_phase & last;
    end else if (state_q == CALC && !active) begin
      out_sr_d = lfsr_q ^ FINAL_XOR;
      cnt_d    = '0;
      state_d  = mode_q ? CHECK : SHIFT;
      valid_d  = !mode_q;
      crc_d    = !mode_q & (lfsr_q[0] ^ FINAL_XOR[0]);
    end else if (out_phase) begin
      err_d   = err_q | miss;
      cnt_d   = last ? cnt_q : cnt_q + 1'b1;
      crc_d   = !last & (state_q == SHIFT) & out_sr_q[cnt_q + 1'b1];
      valid_d = !last & (state_q == SHIFT);
      done_d  = last;
      busy_d  = !last;
      state_d = last ? IDLE : state_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      out_sr_q <= '0;
      crc_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      out_sr_q <= out_sr_d;
      crc_q    <= crc_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign crc   = crc_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: directed frames against four parameterisations with hand-computed CRCs
module tb_crc_serial_engine;
  logic       clk, rst_n, data, active, mode;
  logic [3:0] crc_w, valid_w, busy_w, done_w, err_w;
  logic [1:0] sel;
  logic       obs_crc, obs_valid, obs_busy, obs_done, obs_err;
  int         tests, fails, cyc, t0, vc, dc, rel;
  logic [31:0] val;
  logic       v1, d1, b1, e1;

  // a: POLY 0 (CRC = data ^ SEED), b: one-bit frame vector, c: 16-bit, d: default poly with FINAL_XOR
  crc_serial_engine #(.CRC_WIDTH(8), .POLY(8'h00), .SEED(8'hD8), .FINAL_XOR(8'h00)) u_a (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active), .mode(mode),
    .crc(crc_w[0]), .valid(valid_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]));
  crc_serial_engine #(.CRC_WIDTH(8), .POLY(8'h44), .SEED(8'h00), .FINAL_XOR(8'h00)) u_b (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active), .mode(mode),
    .crc(crc_w[1]), .valid(valid_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]));
  crc_serial_engine #(.CRC_WIDTH(16), .POLY(16'h0044), .SEED(16'h0000), .FINAL_XOR(16'h0000)) u_c (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active), .mode(mode),
    .crc(crc_w[2]), .valid(valid_w[2]), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]));
  crc_serial_engine #(.CRC_WIDTH(8), .POLY(8'h44), .SEED(8'hD8), .FINAL_XOR(8'h0F)) u_d (
    .clk(clk), .rst_n(rst_n), .data(data), .active(active), .mode(mode),
    .crc(crc_w[3]), .valid(valid_w[3]), .busy(busy_w[3]), .done(done_w[3]), .err(err_w[3]));

  always_comb begin
    obs_crc   = crc_w[sel];
    obs_valid = valid_w[sel];
    obs_busy  = busy_w[sel];
    obs_done  = done_w[sel];
    obs_err   = err_w[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MODE is inverted after the first bit to show it is only sampled at frame start.
  task automatic send_frame(input logic [31:0] bits, input int n, input logic m);
    t0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      active = 1'b1;
      data   = bits[i];
      mode   = (i == 0) ? m : !m;
      tick();
      if (i == 0) begin
        v1 = obs_valid;
        d1 = obs_done;
        b1 = obs_busy;
        e1 = obs_err;
      end
    end
    active = 1'b0;
    data   = 1'b0;
    mode   = 1'b0;
  endtask

  task automatic collect(input int n);
    val = '1;
    vc  = 0;
    dc  = 0;
    rel = -1;
    repeat (n) begin
      tick();
      if (obs_valid) begin
        if (vc < 32) val[vc] = obs_crc;
        vc++;
      end
      if (obs_done) begin
        dc++;
        if (rel < 0) rel = cyc - t0 + 1;
      end
    end
  endtask

  task automatic check_rx(input logic [7:0] c);
    vc = 0;
    dc = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      data = c[i];
      tick();
      if (obs_valid) vc++;
      if (obs_done) dc++;
    end
    data = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; t0 = 0;
    rst_n = 1'b0; data = 1'b0; active = 1'b0; mode = 1'b0; sel = 2'd0;
    idle(2);
    chk("reset_state", 32'({obs_crc, obs_valid, obs_busy, obs_done, obs_err}), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // POLY=0 reduces the CRC to data ^ SEED = 3C ^ D8
    sel = 2'd0;
    send_frame(32'h3C, 8, 1'b0);
    chk("s1_busy_in_frame", 32'(obs_busy), 32'h1);
    collect(12);
    chk("s1_crc", 32'(val[7:0]), 32'hE4);
    chk("s1_valid_cycles", 32'(vc), 32'd8);
    chk("s1_done_count", 32'(dc), 32'd1);
    chk("s1_done_cycle", 32'(rel), 32'd17);
    chk("s1_err", 32'(obs_err), 32'h0);
    chk("s1_busy_after", 32'(obs_busy), 32'h0);

    idle(4);
    sel = 2'd1;
    send_frame(32'h1, 1, 1'b0);
    collect(12);
    chk("s2_crc", 32'(val[7:0]), 32'hC4);
    chk("s2_valid_cycles", 32'(vc), 32'd8);
    chk("s2_done_count", 32'(dc), 32'd1);
    chk("s2_done_cycle", 32'(rel), 32'd10);

    // default poly on 3C from D8 gives A0, then FINAL_XOR 0F -> AF
    idle(4);
    sel = 2'd3;
    send_frame(32'h3C, 8, 1'b0);
    collect(12);
    chk("s3_gen_crc", 32'(val[7:0]), 32'hAF);
    idle(4);
    send_frame(32'h3C, 8, 1'b1);
    check_rx(8'hAF);
    chk("s3_good_done", 32'(obs_done), 32'h1);
    chk("s3_good_err", 32'(obs_err), 32'h0);
    chk("s3_good_busy", 32'(obs_busy), 32'h0);
    chk("s3_check_no_valid", 32'(vc), 32'd0);
    chk("s3_good_done_count", 32'(dc), 32'd1);
    idle(4);
    send_frame(32'h3C, 8, 1'b1);
    check_rx(8'hA7);
    chk("s3_bad_done", 32'(obs_done), 32'h1);
    chk("s3_bad_err", 32'(obs_err), 32'h1);
    idle(3);
    chk("s3_err_held", 32'(obs_err), 32'h1);
    chk("s3_done_pulse", 32'(obs_done), 32'h0);
    send_frame(32'h1, 1, 1'b0);
    chk("s3_err_cleared", 32'(e1), 32'h0);
    collect(12);

    idle(4);
    sel = 2'd0;
    send_frame(32'h3C, 8, 1'b0);
    tick();
    idle(4);
    chk("s4_valid_pre_reset", 32'(obs_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("s4_async_reset", 32'({obs_crc, obs_valid, obs_busy, obs_done, obs_err}), 32'h0);
    chk("s4_reset_all", 32'({valid_w, busy_w, done_w, err_w}), 32'h0);
    tick();
    rst_n = 1'b1;
    idle(2);
    send_frame(32'h3C, 8, 1'b0);
    collect(12);
    chk("s4_crc_after_reset", 32'(val[7:0]), 32'hE4);
    chk("s4_valid_cycles", 32'(vc), 32'd8);

    idle(4);
    send_frame(32'h3C, 8, 1'b0);
    tick();
    idle(2);
    chk("s5_valid_bit2", 32'(obs_valid), 32'h1);
    send_frame(32'h3C, 8, 1'b0);
    chk("s5_abort_valid", 32'(v1), 32'h0);
    chk("s5_abort_no_done", 32'(d1), 32'h0);
    chk("s5_abort_busy", 32'(b1), 32'h1);
    collect(12);
    chk("s5_crc", 32'(val[7:0]), 32'hE4);
    chk("s5_valid_cycles", 32'(vc), 32'd8);
    chk("s5_done_count", 32'(dc), 32'd1);
    chk("s5_done_cycle", 32'(rel), 32'd17);

    // new frame starts on the very edge that retires the last output bit
    idle(4);
    sel = 2'd1;
    send_frame(32'h1, 1, 1'b0);
    tick();
    idle(7);
    chk("s7_valid_last_bit", 32'(obs_valid), 32'h1);
    send_frame(32'h1, 1, 1'b0);
    chk("s7_done_on_restart", 32'(d1), 32'h1);
    chk("s7_busy_on_restart", 32'(b1), 32'h1);
    chk("s7_valid_on_restart", 32'(v1), 32'h0);
    collect(12);
    chk("s7_crc", 32'(val[7:0]), 32'hC4);
    chk("s7_done_cycle", 32'(rel), 32'd10);

    idle(30);
    sel = 2'd2;
    send_frame(32'h0, 16, 1'b0);
    collect(22);
    chk("s6_crc16", 32'(val[15:0]), 32'h0);
    chk("s6_valid_cycles", 32'(vc), 32'd16);
    chk("s6_done_count", 32'(dc), 32'd1);
    chk("s6_done_cycle", 32'(rel), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
